// File: rtl/cic_comb_chain.sv
// cic_comb_chain: cascaded multi-channel CIC comb sections y[n] = x[n] - x[n-DELAY]
module cic_comb_chain #(
    parameter int WIDTH    = 64,
    parameter int STAGES   = 4,
    parameter int DELAY    = 1,
    parameter int CHANNELS = 1,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clk_en_i,
    input  logic             clear_i,
    input  logic             valid_i,
    input  logic [CHW-1:0]   ch_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [CHW-1:0]   ch_o,
    output logic [WIDTH-1:0] data_o,
    output logic             err_o
);
    localparam int PW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [CHW:0] NCH = (CHW + 1)'(CHANNELS);
    localparam logic [PW-1:0] PLAST = PW'(DELAY - 1);

    logic          in_range;
    logic          accept;
    logic [PW-1:0] wp [CHANNELS];
    logic [PW-1:0] wp_cur;
    logic [PW-1:0] wp_nxt;

    assign in_range = {1'b0, ch_i} < NCH;
    assign accept   = clk_en_i && valid_i && !clear_i && in_range;
    assign wp_cur   = wp[ch_i];
    assign wp_nxt   = (wp_cur == PLAST) ? '0 : wp_cur + PW'(1);

    // Per-channel write pointer, advanced once per accepted sample of that channel
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i || clear_i) begin
            for (int c = 0; c < CHANNELS; c++) wp[c] <= '0;
        end else if (accept) begin
            wp[ch_i] <= wp_nxt;
        end
    end

    // Sticky flag for samples tagged with a channel that does not exist
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            err_o <= 1'b0;
        else if (clk_en_i && valid_i && !clear_i && !in_range)
            err_o <= 1'b1;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_st
        logic             vld;
        logic [CHW-1:0]   chs;
        logic [PW-1:0]    ptr;
        logic [WIDTH-1:0] dat;
        logic [WIDTH-1:0] hist [CHANNELS][DELAY];
        logic             iv;
        logic [CHW-1:0]   ic;
        logic [PW-1:0]    ip;
        logic [WIDTH-1:0] id;
        if (s == 0) begin : g_in
            assign iv = accept;
            assign ic = ch_i;
            assign ip = wp_cur;
            assign id = data_i;
        end else begin : g_in
            assign iv = g_st[s-1].vld;
            assign ic = g_st[s-1].chs;
            assign ip = g_st[s-1].ptr;
            assign id = g_st[s-1].dat;
        end
        // One comb section: subtract the sample DELAY steps back in this channel, then store the new one
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                vld <= 1'b0;
                chs <= '0;
                ptr <= '0;
                dat <= '0;
                for (int c = 0; c < CHANNELS; c++)
                    for (int d = 0; d < DELAY; d++) hist[c][d] <= '0;
            end else if (clear_i) begin
                vld <= 1'b0;
                for (int c = 0; c < CHANNELS; c++)
                    for (int d = 0; d < DELAY; d++) hist[c][d] <= '0;
            end else if (clk_en_i) begin
                vld <= iv;
                if (iv) begin
                    chs          <= ic;
                    ptr          <= ip;
                    dat          <= id - hist[ic][ip];
                    hist[ic][ip] <= id;
                end
            end
        end
    end

    assign valid_o = g_st[STAGES-1].vld;
    assign ch_o    = g_st[STAGES-1].chs;
    assign data_o  = g_st[STAGES-1].dat;
endmodule

// File: tb/tb_cic_comb_chain.sv
// tb_cic_comb_chain: randomized check of the comb cascade against a binomial-sum reference
module tb_cic_comb_chain;
    localparam int W = 16;
    localparam int S = 3;
    localparam int M = 2;
    localparam int C = 3;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           reset_i = 1'b1;
    logic           clk_en_i = 1'b0;
    logic           clear_i = 1'b0;
    logic           valid_i = 1'b0;
    logic [CHW-1:0] ch_i = '0;
    logic [W-1:0]   data_i = '0;
    logic           valid_o;
    logic [CHW-1:0] ch_o;
    logic [W-1:0]   data_o;
    logic           err_o;

    cic_comb_chain #(.WIDTH(W), .STAGES(S), .DELAY(M), .CHANNELS(C)) dut (
        .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i), .clear_i(clear_i),
        .valid_i(valid_i), .ch_i(ch_i), .data_i(data_i),
        .valid_o(valid_o), .ch_o(ch_o), .data_o(data_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {bit v; int c; logic [W-1:0] d;} ent_t;
    ent_t         line[$];
    longint       xs[C][$];
    bit           mv;
    logic [W-1:0] md;
    int           mc;
    bit           merr;

    function automatic longint binom(int n, int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // S cascaded combs of delay M equal sum_k (-1)^k C(S,k) x[n-kM], zeros before the first sample
    function automatic logic [W-1:0] comb_out(int ch);
        longint acc = 0;
        int n = xs[ch].size() - 1;
        for (int k = 0; k <= S; k++) begin
            int idx = n - k * M;
            if (idx >= 0) acc += ((k % 2) ? -1 : 1) * binom(S, k) * xs[ch][idx];
        end
        return acc[W-1:0];
    endfunction

    task automatic model_reset();
        ent_t e = '{0, 0, '0};
        line.delete();
        for (int i = 0; i < S - 1; i++) line.push_back(e);
        for (int c = 0; c < C; c++) xs[c].delete();
        mv = 0; md = '0; mc = 0; merr = 0;
    endtask

    task automatic model_step(input bit en, input bit clr, input bit v, input int ch, input logic [W-1:0] d);
        ent_t e = '{0, 0, '0};
        if (clr) begin
            foreach (line[i]) line[i].v = 0;
            for (int c = 0; c < C; c++) xs[c].delete();
            mv = 0;
        end else if (en) begin
            if (v && ch >= C) merr = 1;
            if (v && ch < C) begin
                xs[ch].push_back(longint'(d));
                e = '{1, ch, comb_out(ch)};
            end
            line.push_front(e);
            e = line.pop_back();
            mv = e.v;
            if (e.v) begin md = e.d; mc = e.c; end
        end
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, "_valid"}, 64'(valid_o), 64'(mv));
        chk({pfx, "_data"}, 64'(data_o), 64'(md));
        chk({pfx, "_ch"}, 64'(ch_o), 64'(mc));
        chk({pfx, "_err"}, 64'(err_o), 64'(merr));
    endtask

    task automatic cycle(input bit en, input bit clr, input bit v, input int ch, input logic [W-1:0] d);
        @(negedge clk);
        check_outputs("out");
        clk_en_i = en; clear_i = clr; valid_i = v; ch_i = CHW'(ch); data_i = d;
        @(posedge clk);
        model_step(en, clr, v, ch, d);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 reset_i = 1'b1;
        #1 model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        clk_en_i = 0; valid_i = 0; clear_i = 0;
    endtask

    task automatic run_random(input int n, input int max_ch);
        for (int i = 0; i < n; i++)
            cycle($urandom_range(0, 9) < 8, $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8,
                  $urandom_range(0, max_ch), W'($urandom));
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        reset_i = 1'b0;
        cycle(1, 0, 1, 0, 16'd10);
        cycle(1, 0, 1, 1, 16'd100);
        cycle(1, 0, 1, 0, 16'd20);
        cycle(1, 0, 1, 1, 16'd150);
        cycle(1, 0, 1, 0, 16'd30);
        cycle(1, 0, 1, 0, 16'h7fff);
        cycle(0, 0, 1, 0, 16'd5);
        cycle(1, 0, 1, 0, 16'h8000);
        repeat (S + 2) cycle(1, 0, 0, 0, '0);
        cycle(1, 0, 1, 2, 16'd1);
        cycle(1, 0, 1, 2, 16'd0);
        cycle(1, 1, 1, 2, 16'd44);
        cycle(1, 0, 1, 2, 16'd9);
        repeat (S + 2) cycle(1, 0, 0, 0, '0);
        run_random(600, 2);
        cycle(1, 0, 1, 3, 16'd77);
        repeat (S + 1) cycle(1, 0, 0, 0, '0);
        run_random(600, 3);
        pulse_reset();
        cycle(1, 0, 1, 0, 16'd9);
        repeat (S + 1) cycle(1, 0, 0, 0, '0);
        run_random(800, 3);
        repeat (S + 1) cycle(1, 0, 0, 0, '0);
        @(negedge clk);
        check_outputs("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
